subband_combiner: RTL and testbench

SUBBAND_COMBINER -- requirements
Module: subband_combiner

---
 rtl/subband_pkg.sv | 23 ++
 rtl/subband_combiner_sat_round.sv | 37 +++
 rtl/subband_combiner.sv | 119 +++++++++++
 tb/tb_subband_combiner.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/subband_pkg.sv
// Shared constants and types for the subband combiner.
// Widths, gain format, unity gain and the FSM state enum.
package subband_pkg;

  localparam int NUM_BANDS = 16;
  localparam int IN_W      = 31;
  localparam int GAIN_W    = 12;
  localparam int GAIN_FRAC = 10;
  localparam int OUT_W     = 12;
  localparam int SHIFT     = 30;
  localparam int PROD_W    = IN_W + GAIN_W;
  localparam int ACC_W     = 48;

  localparam logic signed [GAIN_W-1:0] UNITY_GAIN =
    GAIN_W'(1 << GAIN_FRAC);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    EMIT
  } state_t;

endpackage

// File: rtl/subband_combiner_sat_round.sv
// Combinational round-half-up, arithmetic shift and clamp.
// Ports: acc in, y out (OUT_W signed), sat high when clamped.
module sat_round #(
  parameter int ACC_W = 48,
  parameter int OUT_W = 12,
  parameter int SHIFT = 30
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] y,
  output logic                    sat
);

  localparam logic signed [ACC_W:0] ONE  = (ACC_W+1)'(1);
  localparam logic signed [ACC_W:0] HALF = ONE <<< (SHIFT-1);
  localparam logic signed [ACC_W:0] MAXV =
    (ONE <<< (OUT_W-1)) - ONE;
  localparam logic signed [ACC_W:0] MINV = -MAXV - ONE;

  logic signed [ACC_W:0] rnd;
  logic signed [ACC_W:0] shd;

  // One guard bit so adding the half LSB can never wrap.
  always_comb begin
    rnd = $signed({acc[ACC_W-1], acc}) + HALF;
    shd = rnd >>> SHIFT;
    y   = shd[OUT_W-1:0];
    sat = 1'b0;
    if (shd > MAXV) begin
      y   = MAXV[OUT_W-1:0];
      sat = 1'b1;
    end else if (shd < MINV) begin
      y   = MINV[OUT_W-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/subband_combiner.sv
// Gain-weighted sum of NUM_BANDS subband samples, one band per cycle.
// Ports: band_in/frame_valid/frame_ready frame in, gain write port,
// out_data/out_valid result, sticky sat_flag/drop_flag, sat_clr.
module subband_combiner
  import subband_pkg::*;
#(
  parameter int NUM_BANDS = subband_pkg::NUM_BANDS,
  parameter int IN_W      = subband_pkg::IN_W,
  parameter int GAIN_W    = subband_pkg::GAIN_W,
  parameter int OUT_W     = subband_pkg::OUT_W,
  parameter int SHIFT     = subband_pkg::SHIFT
) (
  input  logic                         clk_en,
  input  logic                         reset,
  input  logic [NUM_BANDS*IN_W-1:0]    band_in,
  input  logic                         frame_valid,
  output logic                         frame_ready,
  input  logic                         gain_wr_en,
  input  logic [$clog2(NUM_BANDS)-1:0] gain_addr,
  input  logic [GAIN_W-1:0]            gain_data,
  input  logic                         sat_clr,
  output logic [OUT_W-1:0]             out_data,
  output logic                         out_valid,
  output logic                         sat_flag,
  output logic                         drop_flag
);

  localparam int IDX_W = $clog2(NUM_BANDS);
  localparam int MUL_W = IN_W + GAIN_W;

  state_t state, state_n;

  logic        [IDX_W-1:0] band_idx;
  logic signed [IN_W-1:0]  band_snap [NUM_BANDS];
  logic signed [GAIN_W-1:0] gain     [NUM_BANDS];
  logic signed [ACC_W-1:0] acc;
  logic signed [MUL_W-1:0] prod;
  logic signed [OUT_W-1:0] sr_y;
  logic                    sr_sat;
  logic                    last_band;
  logic                    accept;
  logic                    drop_evt;
  logic                    sat_evt;

  assign frame_ready = (state == IDLE);
  assign accept      = (state == IDLE) && frame_valid;
  assign drop_evt    = (state != IDLE) && frame_valid;
  assign sat_evt     = (state == EMIT) && sr_sat;
  assign last_band   = (band_idx == IDX_W'(NUM_BANDS-1));

  assign prod = MUL_W'(band_snap[band_idx])
              * MUL_W'(gain[band_idx]);

  sat_round #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_sat_round (
    .acc (acc),
    .y   (sr_y),
    .sat (sr_sat)
  );

  always_ff @(posedge clk_en) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (frame_valid) state_n = ACCUM;
      ACCUM:   if (last_band)   state_n = EMIT;
      EMIT:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Samples are only meaningful after an accept; no reset needed.
  always_ff @(posedge clk_en) begin
    if (accept) begin
      for (int i = 0; i < NUM_BANDS; i++)
        band_snap[i] <= band_in[i*IN_W +: IN_W];
    end
  end

  always_ff @(posedge clk_en) begin
    if (reset) begin
      acc       <= '0;
      band_idx  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
      drop_flag <= 1'b0;
      for (int i = 0; i < NUM_BANDS; i++)
        gain[i] <= UNITY_GAIN;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        acc      <= '0;
        band_idx <= '0;
      end
      if (state == ACCUM) begin
        acc      <= acc + ACC_W'(prod);
        band_idx <= band_idx + 1'b1;
      end
      if (state == EMIT) begin
        out_data  <= sr_y;
        out_valid <= 1'b1;
      end
      // ACCUM reads above use the pre-edge gain value.
      if (gain_wr_en)
        gain[gain_addr] <= gain_data;
      sat_flag  <= sat_evt  | (sat_flag  & ~sat_clr);
      drop_flag <= drop_evt | (drop_flag & ~sat_clr);
    end
  end

endmodule

// File: tb/tb_subband_combiner.sv
// Random and directed bench for subband_combiner.
// Cycle reference model of the frame/gain/flag rules.
module tb_subband_combiner;
  import subband_pkg::*;

  logic                      clk_en = 1'b0;
  logic                      reset;
  logic [NUM_BANDS*IN_W-1:0] band_in;
  logic                      frame_valid;
  logic                      frame_ready;
  logic                      gain_wr_en;
  logic [3:0]                gain_addr;
  logic [GAIN_W-1:0]         gain_data;
  logic                      sat_clr;
  logic [OUT_W-1:0]          out_data;
  logic                      out_valid;
  logic                      sat_flag;
  logic                      drop_flag;

  int n_vec = 0;
  int n_bad = 0;

  longint m_gain [NUM_BANDS];
  longint m_snap [NUM_BANDS];
  longint m_acc;
  longint m_out;
  int     m_age;
  bit     m_valid = 1'b0;
  bit     m_sat;
  bit     m_drop;

  int     edge_no = 0;
  int     acc_edge = 0;
  int     out_edge = 0;
  int     n_valid = 0;
  longint last_val = 0;

  always #5 clk_en = ~clk_en;

  subband_combiner dut (
    .clk_en      (clk_en),
    .reset       (reset),
    .band_in     (band_in),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .gain_wr_en  (gain_wr_en),
    .gain_addr   (gain_addr),
    .gain_data   (gain_data),
    .sat_clr     (sat_clr),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .sat_flag    (sat_flag),
    .drop_flag   (drop_flag)
  );

  task automatic chk(string tag, longint got, longint exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_band(int k, longint v);
    band_in[k*IN_W +: IN_W] = v[IN_W-1:0];
  endtask

  task automatic clr_bands();
    band_in = '0;
  endtask

  // Model evaluates the coming edge from current inputs,
  // then the edge happens and the DUT is compared 1 ns later.
  task automatic tick();
    bit     set_d;
    bit     set_s;
    longint r;
    set_d   = 1'b0;
    set_s   = 1'b0;
    m_valid = 1'b0;
    if (reset) begin
      m_age  = -1;
      m_out  = 0;
      m_sat  = 1'b0;
      m_drop = 1'b0;
      for (int i = 0; i < NUM_BANDS; i++) m_gain[i] = 1024;
    end else begin
      if (m_age < 0) begin
        if (frame_valid) begin
          for (int i = 0; i < NUM_BANDS; i++)
            m_snap[i] = longint'($signed(band_in[i*IN_W +: IN_W]));
          m_acc    = 0;
          m_age    = 0;
          acc_edge = edge_no + 1;
        end
      end else begin
        if (frame_valid) set_d = 1'b1;
        if (m_age < NUM_BANDS) begin
          m_acc += m_snap[m_age] * m_gain[m_age];
          m_age++;
        end else begin
          r = (m_acc + (longint'(1) <<< (SHIFT-1))) >>> SHIFT;
          if (r > 2047) begin
            r = 2047;
            set_s = 1'b1;
          end else if (r < -2048) begin
            r = -2048;
            set_s = 1'b1;
          end
          m_out   = r;
          m_valid = 1'b1;
          m_age   = -1;
        end
      end
      if (gain_wr_en)
        m_gain[gain_addr] = longint'($signed(gain_data));
      m_sat  = set_s | (m_sat  & !sat_clr);
      m_drop = set_d | (m_drop & !sat_clr);
    end
    @(posedge clk_en);
    edge_no++;
    #1;
    chk("out_valid",   out_valid, m_valid);
    chk("out_data",    longint'($signed(out_data)), m_out);
    chk("frame_ready", frame_ready, (m_age < 0));
    chk("sat_flag",    sat_flag, m_sat);
    chk("drop_flag",   drop_flag, m_drop);
    if (out_valid) begin
      last_val = longint'($signed(out_data));
      out_edge = edge_no;
      n_valid++;
    end
  endtask

  task automatic run_frame();
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    repeat (18) tick();
  endtask

  initial begin
    int             n_before;
    logic [30:0]    raw;
    logic signed [30:0] sv;
    reset       = 1'b1;
    frame_valid = 1'b0;
    gain_wr_en  = 1'b0;
    gain_addr   = '0;
    gain_data   = '0;
    sat_clr     = 1'b0;
    band_in     = '0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("rst_ready", frame_ready, 1);
    chk("rst_data",  longint'($signed(out_data)), 0);

    // Single band at unity gain
    clr_bands();
    set_band(0, 64'sd1 <<< 29);
    run_frame();
    chk("r031_data", last_val, 512);
    chk("r031_lat",  out_edge - acc_edge, 17);
    chk("r031_sat",  sat_flag, 0);

    // Full-scale sum clamps
    for (int k = 0; k < NUM_BANDS; k++) set_band(k, 64'sd1 <<< 29);
    run_frame();
    chk("r032_data", last_val, 2047);
    chk("r032_sat",  sat_flag, 1);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    clr_bands();
    set_band(0, -(64'sd1 <<< 29));
    run_frame();
    chk("r032_neg", last_val, -512);

    // Rounding of exact halves
    clr_bands();
    set_band(0, 64'sd3 <<< 19);
    run_frame();
    chk("r033_pos", last_val, 2);
    clr_bands();
    set_band(0, -(64'sd3 <<< 19));
    run_frame();
    chk("r033_neg", last_val, -1);

    // Gain write and dropped frame during ACCUM
    gain_wr_en = 1'b1;
    gain_addr  = 4'd5;
    gain_data  = 12'd512;
    tick();
    gain_wr_en = 1'b0;
    clr_bands();
    set_band(5, 64'sd1 <<< 29);
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    repeat (3) tick();
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    repeat (16) tick();
    chk("r034_data", last_val, 256);
    chk("r034_drop", drop_flag, 1);

    // Reset in the middle of accumulation
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    repeat (8) tick();
    n_before = n_valid;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (20) tick();
    chk("r035_noval", n_valid, n_before);
    chk("r035_data",  longint'($signed(out_data)), 0);
    run_frame();
    chk("r035_gain",  last_val, 512);

    // Randomized traffic
    for (int it = 0; it < 1500; it++) begin
      for (int k = 0; k < NUM_BANDS; k++) begin
        raw = 31'($urandom);
        sv  = $signed(raw) >>> ($urandom % 16);
        band_in[k*IN_W +: IN_W] = sv;
      end
      frame_valid = ($urandom % 3) == 0;
      gain_wr_en  = ($urandom % 4) == 0;
      gain_addr   = 4'($urandom);
      gain_data   = 12'($urandom);
      sat_clr     = ($urandom % 8) == 0;
      reset       = ($urandom % 300) == 0;
      tick();
    end
    reset       = 1'b0;
    frame_valid = 1'b0;
    gain_wr_en  = 1'b0;
    sat_clr     = 1'b0;
    repeat (20) tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
